// File: rtl/req_arb_pkg.sv
// Shared defaults, FSM state type and one-hot helper for the request arbiter.
package req_arb_pkg;

   localparam int N    = 8;
   localparam int IDXW = $clog2(N);

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   function automatic logic [IDXW-1:0] onehot2idx(input logic [N-1:0] oh);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (oh[i]) idx = idx | IDXW'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot pick: first set bit after ptr with wrap-around.
// With REQ_ARB_FIXED_PRIO_EN defined it becomes a plain lowest-index pick.
module rr_pick #(
   parameter int N    = req_arb_pkg::N,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    vec,
`ifndef REQ_ARB_FIXED_PRIO_EN
   input  logic [IDXW-1:0] ptr,
`endif
   output logic [N-1:0]    gnt
);

   logic found;

`ifdef REQ_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!found && vec[i]) begin
            gnt[i] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`else
   logic [IDXW-1:0] idx;

   // N is a power of two, so truncating ptr+k to IDXW bits is the modulo wrap
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = ptr + IDXW'(k);
         if (!found && vec[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/req_rr_arbiter.sv
// Pending-request collector with registered one-hot grant and valid/ready handshake.
// Round-robin by default; REQ_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module req_rr_arbiter #(
   parameter int N    = req_arb_pkg::N,
   parameter int IDXW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req_in,
   output logic [N-1:0] grant,
   output logic         grant_valid,
   input  logic         grant_ready,
   output logic [N-1:0] pending,
   output logic         lost,
   input  logic         lost_clr
);
   import req_arb_pkg::*;

   state_t       state, state_d;
   logic [N-1:0] grant_d, pending_d, accepted, rem, pick_vec, pick_gnt;
   logic         valid_d, lost_d, hs;

`ifndef REQ_ARB_FIXED_PRIO_EN
   localparam int NPKG = req_arb_pkg::N;
   logic [IDXW-1:0] ptr, ptr_d, grant_idx, pick_ptr;

   assign grant_idx = IDXW'(onehot2idx(NPKG'(grant)));
   // In OFFER the next pick must already use the post-handshake pointer
   assign pick_ptr  = (state == OFFER) ? grant_idx : ptr;
`endif

   assign hs       = grant_valid & grant_ready;
   assign accepted = hs ? grant : '0;
   assign rem      = pending & ~grant;
   // One picker serves both states: IDLE picks from pending, OFFER from the remainder
   assign pick_vec = (state == OFFER) ? rem : pending;

   rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .vec (pick_vec),
`ifndef REQ_ARB_FIXED_PRIO_EN
      .ptr (pick_ptr),
`endif
      .gnt (pick_gnt)
   );

   always_comb begin
      pending_d = (pending & ~accepted) | req_in;
      lost_d    = (|(req_in & pending & ~accepted)) | (lost & ~lost_clr);
      state_d   = state;
      grant_d   = grant;
      valid_d   = grant_valid;
`ifndef REQ_ARB_FIXED_PRIO_EN
      ptr_d     = ptr;
`endif
      case (state)
         IDLE: begin
            if (|pending) begin
               grant_d = pick_gnt;
               valid_d = 1'b1;
               state_d = OFFER;
            end else begin
               grant_d = '0;
               valid_d = 1'b0;
            end
         end
         OFFER: begin
            if (hs) begin
`ifndef REQ_ARB_FIXED_PRIO_EN
               ptr_d = grant_idx;
`endif
               if (|rem) begin
                  grant_d = pick_gnt;
               end else begin
                  grant_d = '0;
                  valid_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            grant_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         pending     <= '0;
         lost        <= 1'b0;
`ifndef REQ_ARB_FIXED_PRIO_EN
         ptr         <= IDXW'(N - 1);
`endif
      end else begin
         state       <= state_d;
         grant       <= grant_d;
         grant_valid <= valid_d;
         pending     <= pending_d;
         lost        <= lost_d;
`ifndef REQ_ARB_FIXED_PRIO_EN
         ptr         <= ptr_d;
`endif
      end
   end

endmodule
